// File: rtl/lm_sm_pkg.sv
// Shared constants for the LM/SM multi-register load/store sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lm_sm_pkg;

    localparam int MASK_W = 8;
    localparam int ADDR_W = 16;
    localparam int IDX_W  = 3;

    localparam logic [3:0] OPC_LM = 4'b0110;
    localparam logic [3:0] OPC_SM = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FINISH = 2'b10
    } state_t;

    function automatic logic is_lm_sm(input logic [3:0] opc);
        return (opc == OPC_LM) || (opc == OPC_SM);
    endfunction

endpackage

// File: rtl/lm_sm_pri_enc.sv
// Lowest-set-bit priority encoder over the remaining register mask.
// Latency: purely combinational.
// Backpressure: none.
// Ports: mask in; idx = index of lowest set bit (0 when mask is 0); any_set = |mask.
module lm_sm_pri_enc
    import lm_sm_pkg::*;
(
    input  logic [MASK_W-1:0] mask,
    output logic [IDX_W-1:0]  idx,
    output logic              any_set
);

    // Scanning from the top down lets the lowest set bit win the last assignment.
    always_comb begin
        idx     = '0;
        any_set = |mask;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: expands one multi-register load/store into per-register micro-ops.
// Latency: first micro-op the cycle after start accept; k-bit mask -> k RUN cycles + 1 FINISH.
// Backpressure: micro-op held stable while uop_ready is low; fetch/decode stalled throughout.
// Ports: clk/rst (async active-low); start_valid/inst_word/base_addr from decode;
//        uop_* to the memory stage; flush squashes; done pulses on completion.
// Optional: define LM_SM_PERF_CNT_EN to add the uop_count accepted-micro-op counter.
module lm_sm_sequencer
    import lm_sm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    input  logic [15:0]       inst_word,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              uop_ready,
    input  logic              flush,
    output logic              start_ready,
    output logic              stall_out,
    output logic              uop_valid,
    output logic              uop_is_load,
    output logic [IDX_W-1:0]  uop_reg,
    output logic [ADDR_W-1:0] uop_addr,
    output logic              done
`ifdef LM_SM_PERF_CNT_EN
    ,
    output logic [ADDR_W-1:0] uop_count
`endif
);

    state_t              state_q, state_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                is_load_q, is_load_d;

    logic [IDX_W-1:0]    low_idx;
    logic                low_any;
    logic [MASK_W-1:0]   low_onehot;
    logic [MASK_W-1:0]   mask_after;
    logic                start_acc;
    logic                uop_fire;
    logic                unused_inst_bits;

    // Bits [11:8] carry no meaning for LM/SM here.
    assign unused_inst_bits = ^{inst_word[11:8], low_any};

    lm_sm_pri_enc u_pri_enc (
        .mask    (mask_q),
        .idx     (low_idx),
        .any_set (low_any)
    );

    assign start_acc = (state_q == ST_IDLE) && start_valid
                       && is_lm_sm(inst_word[15:12]) && !flush;
    assign uop_fire  = (state_q == ST_RUN) && uop_ready;

    always_comb begin
        low_onehot          = '0;
        low_onehot[low_idx] = 1'b1;
        mask_after          = mask_q & ~low_onehot;
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        addr_d      = addr_q;
        is_load_d   = is_load_q;
        start_ready = 1'b0;
        stall_out   = 1'b0;
        uop_valid   = 1'b0;
        uop_is_load = 1'b0;
        uop_reg     = '0;
        uop_addr    = '0;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_acc) begin
                    stall_out = 1'b1;
                    mask_d    = inst_word[MASK_W-1:0];
                    addr_d    = base_addr;
                    is_load_d = (inst_word[15:12] == OPC_LM);
                    state_d   = (|inst_word[MASK_W-1:0]) ? ST_RUN : ST_FINISH;
                end
            end
            ST_RUN: begin
                stall_out   = 1'b1;
                uop_valid   = 1'b1;
                uop_is_load = is_load_q;
                uop_reg     = low_idx;
                uop_addr    = addr_q;
                if (uop_fire) begin
                    mask_d = mask_after;
                    addr_d = addr_q + 1'b1;
                    if (mask_after == '0) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                stall_out = 1'b1;
                done      = !flush;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Squash wins over every other transition.
        if (flush) begin
            state_d = ST_IDLE;
            mask_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            addr_q    <= '0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            is_load_q <= is_load_d;
        end
    end

`ifdef LM_SM_PERF_CNT_EN
    logic [ADDR_W-1:0] uop_count_q, uop_count_d;

    // A handshake squashed by flush is not counted as accepted.
    always_comb begin
        uop_count_d = uop_count_q;
        if (uop_fire && !flush) begin
            uop_count_d = uop_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uop_count_q <= '0;
        end else begin
            uop_count_q <= uop_count_d;
        end
    end

    assign uop_count = uop_count_q;
`endif

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: directed vectors plus queue-based reference model.
// Latency: n/a.
// Backpressure: exercised via uop_ready held low on a micro-op.
module tb_lm_sm_sequencer;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic [15:0] inst_word;
    logic [15:0] base_addr;
    logic        uop_ready;
    logic        flush;
    logic        start_ready;
    logic        stall_out;
    logic        uop_valid;
    logic        uop_is_load;
    logic [2:0]  uop_reg;
    logic [15:0] uop_addr;
    logic        done;
`ifdef LM_SM_PERF_CNT_EN
    logic [15:0] uop_count;
`endif

    int vectors = 0;
    int fails   = 0;
    bit chk_en  = 0;

    lm_sm_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .inst_word   (inst_word),
        .base_addr   (base_addr),
        .uop_ready   (uop_ready),
        .flush       (flush),
        .start_ready (start_ready),
        .stall_out   (stall_out),
        .uop_valid   (uop_valid),
        .uop_is_load (uop_is_load),
        .uop_reg     (uop_reg),
        .uop_addr    (uop_addr),
        .done        (done)
`ifdef LM_SM_PERF_CNT_EN
        ,
        .uop_count   (uop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a start expands the mask into a list of (reg, addr) pairs;
    // the head of the list is what must be on the micro-op port, an empty list
    // with m_done set is the completion cycle.
    typedef struct packed {
        logic [2:0]  r;
        logic [15:0] a;
    } uop_t;

    uop_t exp_q[$];
    bit   m_done = 0;
    bit   m_load = 0;
    int   m_cnt  = 0;

    function automatic bit op_ok(input logic [15:0] w);
        return (w[15:12] == 4'b0110) || (w[15:12] == 4'b0111);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                exp_q.delete();
                m_done = 0;
                m_load = 0;
                m_cnt  = 0;
            end else if (flush) begin
                exp_q.delete();
                m_done = 0;
            end else if (exp_q.size() == 0 && !m_done) begin
                if (start_valid && op_ok(inst_word)) begin
                    int n;
                    n = 0;
                    m_load = (inst_word[15:12] == 4'b0110);
                    for (int j = 0; j < 8; j++) begin
                        if (inst_word[j]) begin
                            uop_t u;
                            u.r = 3'(j);
                            u.a = base_addr + 16'(n);
                            exp_q.push_back(u);
                            n++;
                        end
                    end
                    if (n == 0) m_done = 1;
                end
            end else if (exp_q.size() > 0) begin
                if (uop_ready) begin
                    void'(exp_q.pop_front());
                    m_cnt = (m_cnt + 1) % 65536;
                    if (exp_q.size() == 0) m_done = 1;
                end
            end else begin
                m_done = 0;
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                bit   idle_m;
                bit   v;
                uop_t h;
                idle_m = (exp_q.size() == 0) && !m_done;
                v      = exp_q.size() > 0;
                h      = v ? exp_q[0] : '0;
                check("m_start_ready", 32'(start_ready), 32'(idle_m));
                check("m_stall_out", 32'(stall_out),
                      32'(!idle_m || (start_valid && op_ok(inst_word) && !flush)));
                check("m_uop_valid", 32'(uop_valid), 32'(v));
                check("m_uop_reg", 32'(uop_reg), 32'(h.r));
                check("m_uop_addr", 32'(uop_addr), 32'(h.a));
                check("m_uop_is_load", 32'(uop_is_load), 32'(v && m_load));
                check("m_done", 32'(done), 32'(m_done && !flush));
`ifdef LM_SM_PERF_CNT_EN
                check("m_uop_count", 32'(uop_count), 32'(m_cnt));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        #3;
    endtask

    task automatic start(input logic [15:0] w, input logic [15:0] b);
        start_valid = 1'b1;
        inst_word   = w;
        base_addr   = b;
    endtask

    initial begin
        rst         = 1'b0;
        start_valid = 1'b0;
        inst_word   = '0;
        base_addr   = '0;
        uop_ready   = 1'b1;
        flush       = 1'b0;
        #2;
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_uop_valid", 32'(uop_valid), 32'd0);
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        cyc();
        cyc();
        rst    = 1'b1;
        chk_en = 1;

        // LM mask 0x81 from 0x0100.
        cyc();
        start(16'h6081, 16'h0100);
        probe();
        check("t1_accept_ready", 32'(start_ready), 32'd1);
        check("t1_accept_stall", 32'(stall_out), 32'd1);
        cyc();
        start_valid = 1'b0;
        probe();
        check("t1_u0_reg", 32'(uop_reg), 32'd0);
        check("t1_u0_addr", 32'(uop_addr), 32'h0100);
        check("t1_u0_load", 32'(uop_is_load), 32'd1);
        cyc();
        probe();
        check("t1_u1_reg", 32'(uop_reg), 32'd7);
        check("t1_u1_addr", 32'(uop_addr), 32'h0101);
        cyc();
        probe();
        check("t1_done", 32'(done), 32'd1);
        check("t1_done_novalid", 32'(uop_valid), 32'd0);
        cyc();
        probe();
        check("t1_idle", 32'(start_ready), 32'd1);

        // SM mask 0xFF from 0xFFFE: address wraps.
        start(16'h70FF, 16'hFFFE);
        cyc();
        start_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] ea;
            ea = 16'hFFFE + 16'(i);
            probe();
            check("t2_valid", 32'(uop_valid), 32'd1);
            check("t2_reg", 32'(uop_reg), 32'(i));
            check("t2_addr", 32'(uop_addr), 32'(ea));
            check("t2_store", 32'(uop_is_load), 32'd0);
            cyc();
        end
        probe();
        check("t2_done", 32'(done), 32'd1);
        cyc();

        // Zero mask: done next cycle, idle the one after.
        start(16'h6000, 16'h1234);
        cyc();
        start_valid = 1'b0;
        probe();
        check("t3_done", 32'(done), 32'd1);
        check("t3_novalid", 32'(uop_valid), 32'd0);
        cyc();
        probe();
        check("t3_idle", 32'(start_ready), 32'd1);

        // SM mask 0x0A with first micro-op stalled 3 cycles.
        uop_ready = 1'b0;
        start(16'h700A, 16'h2000);
        cyc();
        start_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) uop_ready = 1'b1;
            probe();
            check("t4_hold_reg", 32'(uop_reg), 32'd1);
            check("t4_hold_addr", 32'(uop_addr), 32'h2000);
            check("t4_hold_valid", 32'(uop_valid), 32'd1);
            cyc();
        end
        probe();
        check("t4_r3_reg", 32'(uop_reg), 32'd3);
        check("t4_r3_addr", 32'(uop_addr), 32'h2001);
        cyc();
        probe();
        check("t4_done", 32'(done), 32'd1);
        cyc();

        // Flush on the second micro-op of mask 0x07.
        start(16'h6007, 16'h0300);
        cyc();
        start_valid = 1'b0;
        probe();
        check("t5_u0_reg", 32'(uop_reg), 32'd0);
        cyc();
        flush = 1'b1;
        probe();
        check("t5_u1_reg", 32'(uop_reg), 32'd1);
        cyc();
        flush = 1'b0;
        probe();
        check("t5_flushed_idle", 32'(start_ready), 32'd1);
        check("t5_no_done", 32'(done), 32'd0);
        start(16'h6001, 16'h0400);
        cyc();
        start_valid = 1'b0;
        probe();
        check("t5_next_reg", 32'(uop_reg), 32'd0);
        check("t5_next_addr", 32'(uop_addr), 32'h0400);
        cyc();
        probe();
        check("t5_next_done", 32'(done), 32'd1);
        cyc();

        // Non-LM/SM opcode is ignored.
        start(16'h1081, 16'h0500);
        probe();
        check("t6_ready", 32'(start_ready), 32'd1);
        check("t6_nostall", 32'(stall_out), 32'd0);
        cyc();
        start_valid = 1'b0;
        probe();
        check("t6_novalid", 32'(uop_valid), 32'd0);

        // Flush together with start does not start.
        start(16'h6081, 16'h0500);
        flush = 1'b1;
        probe();
        check("t7_nostall", 32'(stall_out), 32'd0);
        cyc();
        start_valid = 1'b0;
        flush       = 1'b0;
        probe();
        check("t7_novalid", 32'(uop_valid), 32'd0);
        check("t7_idle", 32'(start_ready), 32'd1);

        // Asynchronous reset in the middle of RUN.
        start(16'h600F, 16'h0500);
        cyc();
        start_valid = 1'b0;
        probe();
        check("t8_u0_reg", 32'(uop_reg), 32'd0);
        cyc();
        #1;
        rst = 1'b0;
        #1;
        check("t8_rst_valid", 32'(uop_valid), 32'd0);
        check("t8_rst_ready", 32'(start_ready), 32'd1);
        check("t8_rst_stall", 32'(stall_out), 32'd0);
        check("t8_rst_reg", 32'(uop_reg), 32'd0);
        check("t8_rst_addr", 32'(uop_addr), 32'd0);
        check("t8_rst_load", 32'(uop_is_load), 32'd0);
        check("t8_rst_done", 32'(done), 32'd0);
`ifdef LM_SM_PERF_CNT_EN
        check("t8_rst_count", 32'(uop_count), 32'd0);
`endif
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        start(16'h6003, 16'h0600);
        cyc();
        start_valid = 1'b0;
        probe();
        check("t8_after_r0", 32'(uop_reg), 32'd0);
        check("t8_after_a0", 32'(uop_addr), 32'h0600);
        check("t8_after_load", 32'(uop_is_load), 32'd1);
        cyc();
        probe();
        check("t8_after_r1", 32'(uop_reg), 32'd1);
        check("t8_after_a1", 32'(uop_addr), 32'h0601);
        cyc();
        probe();
        check("t8_after_done", 32'(done), 32'd1);
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/lm_sm_sequencer.md
LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst input 1 (asynchronous active-low reset).
REQ-002 The block SHALL have these inputs: start_valid 1 (decode presents an LM/SM instruction); inst_word 16 (instruction, [15:12] opcode, [7:0] register mask); base_addr 16 (base address read from RA); uop_ready 1 (memory stage accepts the micro-op); flush 1 (pipeline squash).
REQ-003 The block SHALL have these outputs: start_ready 1 (sequencer idle, start accepted); stall_out 1 (hold fetch/decode); uop_valid 1 (micro-op valid); uop_is_load 1 (1=LM, 0=SM); uop_reg 3 (register index); uop_addr 16 (memory word address); done 1 (one-cycle completion pulse).

Function
REQ-004 The LM opcode SHALL be 4'b0110 and the SM opcode SHALL be 4'b0111; other opcodes with start_valid high SHALL be ignored (start_ready stays 1, no state change).
REQ-005 The FSM SHALL have states IDLE, RUN and FINISH.
REQ-006 In IDLE, start_valid with a valid LM/SM opcode SHALL latch mask=inst_word[7:0], addr=base_addr and is_load, then enter RUN if mask!=0, else FINISH.
REQ-007 start_ready SHALL be 1 only in IDLE; stall_out SHALL be 1 in RUN and FINISH and in the IDLE cycle that accepts a start.
REQ-008 In RUN, uop_valid SHALL be 1, uop_reg SHALL be the index of the lowest set bit of the remaining mask (bit 0 = R0 first), and uop_addr SHALL be the current addr.
REQ-009 On uop_valid&&uop_ready, the issued bit SHALL clear and addr SHALL increment by 1 modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-010 uop_valid, uop_reg, uop_addr and uop_is_load SHALL hold stable while uop_valid&&!uop_ready.
REQ-011 When the last set bit is accepted, the FSM SHALL enter FINISH on the next edge.
REQ-012 FINISH SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-013 Latency: a start accepted at edge N SHALL give first uop_valid in cycle N+1; a k-bit mask with uop_ready held high SHALL give k RUN cycles plus one FINISH cycle.
REQ-014 A zero mask SHALL produce no micro-op and a done pulse in cycle N+1.
REQ-015 flush in any state SHALL force IDLE at the next edge, clear the mask and suppress done; flush has priority over start, uop_ready and FINISH.
REQ-016 flush and start_valid in the same IDLE cycle SHALL not start a sequence.
REQ-017 uop_is_load, uop_reg and uop_addr SHALL be 0 whenever uop_valid=0.

Reset
REQ-018 rst low SHALL immediately force IDLE, mask=0, addr=0 and is_load=0; all outputs SHALL be 0 except start_ready=1.
REQ-019 Reset asserted mid-sequence SHALL abandon the sequence with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-020 With macro LM_SM_PERF_CNT_EN defined, the block SHALL add output uop_count 16 counting accepted micro-ops; it resets to 0 and wraps at 0xFFFF to 0, and flush does not clear it.
REQ-021 Without LM_SM_PERF_CNT_EN, the uop_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-022 Package lm_sm_pkg SHALL hold the LM/SM opcode constants, the FSM state encoding (2 bits) and the mask/address width parameters.
REQ-023 Lowest-set-bit selection SHALL be a sub-module lm_sm_pri_enc (8-bit mask in, 3-bit index and any-set flag out, purely combinational).

Verification
REQ-024 LM, mask 0x81, base 0x0100, uop_ready=1 -> uops (R0,0x0100), (R7,0x0101); done in the 3rd cycle after accept; is_load=1.
REQ-025 SM, mask 0xFF, base 0xFFFE, uop_ready=1 -> R0..R7 at addresses 0xFFFE, 0xFFFF, 0x0000..0x0005; 8 RUN cycles then done; is_load=0.
REQ-026 LM, mask 0x00 -> no uop_valid; done=1 in cycle N+1; start_ready=1 in cycle N+2.
REQ-027 SM, mask 0x0A, uop_ready low for 3 cycles on the first uop -> R1/addr held stable for 4 cycles, then R3 at base+1.
REQ-028 flush asserted during the 2nd uop of mask 0x07 -> IDLE next edge, no done; a following start of mask 0x01 issues only R0.
REQ-029 rst pulsed low mid-RUN (asynchronously, between edges) -> outputs go to reset values immediately; with LM_SM_PERF_CNT_EN defined, uop_count=0.
